// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bundle between IF0/IF1, the icache and the fetch sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline/cache.
interface if_fetch_ctrl_if #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FB_DEPTH        = 8
);
  localparam int IW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int FW = $clog2(FB_DEPTH) + 1;

  logic          flush;
  logic          pc_valid;
  logic [31:0]   pc;
  logic          pc_ready;
  logic          ic_valid;
  logic [31:0]   ic_addr;
  logic          ic_addr_ok;
  logic          ic_data_ok;
  logic [31:0]   ic_rdata;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_ready;
  logic [IW-1:0] inflight;
  logic [FW-1:0] fb_count;
  logic          proto_err;

  modport slave (
    input  flush, pc_valid, pc, ic_addr_ok, ic_data_ok, ic_rdata, out_ready,
    output pc_ready, ic_valid, ic_addr, out_valid, out_pc, out_inst,
           inflight, fb_count, proto_err
  );

  modport master (
    output flush, pc_valid, pc, ic_addr_ok, ic_data_ok, ic_rdata, out_ready,
    input  pc_ready, ic_valid, ic_addr, out_valid, out_pc, out_inst,
           inflight, fb_count, proto_err
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: issues PCs to the icache, tracks in-flight requests in order,
// drops flush-stale responses and buffers returned instructions for decode.
module if_fetch_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FB_DEPTH        = 8
) (
  input  logic         clk,
  input  logic         rst,
  if_fetch_ctrl_if.slave bus
);
  localparam int IW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int FW = $clog2(FB_DEPTH) + 1;
  localparam int QA = $clog2(MAX_OUTSTANDING);
  localparam int FA = $clog2(FB_DEPTH);

  logic [31:0]   r_pcq [MAX_OUTSTANDING];
  logic [QA-1:0] r_pq_wr, r_pq_rd;
  logic [31:0]   r_fb_pc   [FB_DEPTH];
  logic [31:0]   r_fb_inst [FB_DEPTH];
  logic [FA-1:0] r_fb_wr, r_fb_rd;
  logic [IW-1:0] r_inflight;
  logic [IW-1:0] r_discard;
  logic [FW-1:0] r_fb_count;
  logic          r_proto_err;

  logic [FW:0]   w_occ;
  logic          w_ic_valid, w_issue, w_resp, w_spur, w_push, w_pop;

  // Credit: in-flight requests reserve a buffer slot, so a response always fits.
  assign w_occ      = (FW+1)'(r_inflight) + (FW+1)'(r_fb_count);
  assign w_ic_valid = !rst && bus.pc_valid && !bus.flush &&
                      (r_inflight < IW'(MAX_OUTSTANDING)) &&
                      (w_occ < (FW+1)'(FB_DEPTH));
  assign w_issue    = w_ic_valid && bus.ic_addr_ok;
  assign w_resp     = bus.ic_data_ok && (r_inflight != '0);
  assign w_spur     = bus.ic_data_ok && (r_inflight == '0);
  assign w_push     = w_resp && (r_discard == '0) && !bus.flush;
  assign w_pop      = (r_fb_count != '0) && bus.out_ready && !bus.flush;

  assign bus.ic_valid  = w_ic_valid;
  assign bus.pc_ready  = w_issue;
  assign bus.ic_addr   = bus.pc;
  assign bus.out_valid = !rst && (r_fb_count != '0);
  assign bus.out_pc    = r_fb_pc[r_fb_rd];
  assign bus.out_inst  = r_fb_inst[r_fb_rd];
  assign bus.inflight  = r_inflight;
  assign bus.fb_count  = r_fb_count;
  assign bus.proto_err = r_proto_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pq_wr     <= '0;
      r_pq_rd     <= '0;
      r_fb_wr     <= '0;
      r_fb_rd     <= '0;
      r_inflight  <= '0;
      r_discard   <= '0;
      r_fb_count  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= r_proto_err | w_spur;
      if (w_issue) begin
        r_pcq[r_pq_wr] <= bus.pc;
        r_pq_wr        <= r_pq_wr + 1'b1;
      end
      if (w_resp)
        r_pq_rd <= r_pq_rd + 1'b1;
      case ({w_issue, w_resp})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase

      if (bus.flush) begin
        // Every request still outstanding after this edge is stale, including
        // ones already marked by an earlier flush, so discard tracks inflight.
        r_discard  <= r_inflight - IW'(w_resp);
        r_fb_count <= '0;
        r_fb_rd    <= r_fb_wr;
      end else begin
        if (w_resp && (r_discard != '0))
          r_discard <= r_discard - 1'b1;
        if (w_push) begin
          r_fb_pc[r_fb_wr]   <= r_pcq[r_pq_rd];
          r_fb_inst[r_fb_wr] <= bus.ic_rdata;
          r_fb_wr            <= r_fb_wr + 1'b1;
        end
        if (w_pop)
          r_fb_rd <= r_fb_rd + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_fb_count <= r_fb_count + 1'b1;
          2'b01:   r_fb_count <= r_fb_count - 1'b1;
          default: r_fb_count <= r_fb_count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the fetch path.
module tb_if_fetch_ctrl;
  localparam int MAXO = 4;
  localparam int FBD  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_ctrl_if #(.MAX_OUTSTANDING(MAXO), .FB_DEPTH(FBD)) bus ();

  if_fetch_ctrl #(.MAX_OUTSTANDING(MAXO), .FB_DEPTH(FBD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic [31:0] m_if[$];
  ent_t        m_fb[$];
  int          m_disc;
  bit          m_perr;
  bit          m_issued;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs for the current cycle, then advance the model across the edge.
  task automatic step();
    bit   exp_v, resp;
    ent_t e;
    logic [31:0] h;
    #1;
    exp_v = !rst && bus.pc_valid && !bus.flush && (m_if.size() < MAXO) &&
            (m_if.size() + m_fb.size() < FBD);
    check("ic_valid",  32'(bus.ic_valid),  32'(exp_v));
    check("pc_ready",  32'(bus.pc_ready),  32'(exp_v && bus.ic_addr_ok));
    if (exp_v) check("ic_addr", bus.ic_addr, bus.pc);
    check("out_valid", 32'(bus.out_valid), 32'(!rst && m_fb.size() > 0));
    if (!rst && m_fb.size() > 0) begin
      check("out_pc",   bus.out_pc,   m_fb[0].pc);
      check("out_inst", bus.out_inst, m_fb[0].inst);
    end
    check("inflight",  32'(bus.inflight),  32'(m_if.size()));
    check("fb_count",  32'(bus.fb_count),  32'(m_fb.size()));
    check("proto_err", 32'(bus.proto_err), 32'(m_perr));

    m_issued = exp_v && bus.ic_addr_ok;
    if (rst) begin
      m_if.delete(); m_fb.delete(); m_disc = 0; m_perr = 0; m_issued = 0;
    end else begin
      resp = bus.ic_data_ok && m_if.size() > 0;
      if (bus.ic_data_ok && m_if.size() == 0) m_perr = 1;
      if (!bus.flush && bus.out_ready && m_fb.size() > 0) void'(m_fb.pop_front());
      if (resp) begin
        h = m_if.pop_front();
        if (m_disc > 0) m_disc--;
        else if (!bus.flush) begin
          e.pc = h; e.inst = bus.ic_rdata; m_fb.push_back(e);
        end
      end
      if (bus.flush) begin
        m_fb.delete();
        m_disc = m_if.size();
      end
      if (m_issued) m_if.push_back(bus.pc);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.flush = 0; bus.pc_valid = 0; bus.ic_addr_ok = 0; bus.ic_data_ok = 0;
    bus.out_ready = 0; bus.ic_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; step(); step();
    rst = 0;
  endtask

  // Fill to a target in-flight/buffered split with out_ready held low.
  task automatic build(input int n_if, input int n_fb, input logic [31:0] base);
    bus.pc = base; bus.ic_addr_ok = 1; bus.out_ready = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_if.size() == n_if && m_fb.size() == n_fb) break;
      bus.pc_valid   = (m_if.size() + m_fb.size()) < (n_if + n_fb);
      bus.ic_data_ok = (m_fb.size() < n_fb) && (m_if.size() > 0);
      bus.ic_rdata   = $urandom;
      step();
      if (m_issued) bus.pc = bus.pc + 4;
    end
    idle_inputs();
    check("build_if", 32'(bus.inflight), 32'(n_if));
    check("build_fb", 32'(bus.fb_count), 32'(n_fb));
  endtask

  int hist;

  initial begin
    m_disc = 0; m_perr = 0; m_issued = 0;
    idle_inputs(); bus.pc = 32'h0;
    @(negedge clk);
    do_reset();

    // single fetch
    bus.pc = 32'h1c000000; bus.pc_valid = 1; step();
    bus.ic_addr_ok = 1; step();
    idle_inputs(); step();
    bus.ic_data_ok = 1; bus.ic_rdata = 32'h02800000; step();
    idle_inputs();
    #1;
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_out_pc",    bus.out_pc,         32'h1c000000);
    check("t1_out_inst",  bus.out_inst,       32'h02800000);
    bus.out_ready = 1; step(); idle_inputs();

    // back-to-back until the credit limit
    bus.pc = 32'h1c000000; bus.pc_valid = 1; bus.ic_addr_ok = 1; hist = 0;
    for (int c = 0; c < 16; c++) begin
      bus.ic_data_ok = hist[1];
      bus.ic_rdata   = $urandom;
      step();
      hist = {hist[30:0], m_issued};
      if (m_issued) bus.pc = bus.pc + 4;
    end
    idle_inputs();
    check("t2_fb_count", 32'(bus.fb_count), 32'd8);
    bus.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1 check("t2_order", bus.out_pc, 32'h1c000000 + 32'(4 * i));
      step();
    end
    idle_inputs(); step();

    // flush with 3 in flight and 2 buffered
    build(3, 2, 32'h1c000040);
    bus.flush = 1; bus.pc_valid = 1; bus.pc = 32'h1c000100; step();
    bus.flush = 0; bus.ic_addr_ok = 1; step();
    check("t3_fb_cleared", 32'(bus.fb_count), 32'd0);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.ic_data_ok = 1; bus.ic_rdata = 32'hA000_0000 + 32'(i); step();
      if (i < 3) check("t3_dropped", 32'(bus.fb_count), 32'd0);
    end
    idle_inputs();
    #1 check("t3_out_pc", bus.out_pc, 32'h1c000100);
    check("t3_out_inst", bus.out_inst, 32'hA000_0003);
    bus.out_ready = 1; step(); idle_inputs();

    // flush coinciding with data_ok, two in flight
    build(2, 0, 32'h1c000200);
    bus.flush = 1; bus.ic_data_ok = 1; bus.pc_valid = 1; bus.ic_addr_ok = 1;
    #1 check("t4_no_issue", 32'(bus.ic_valid), 32'd0);
    step();
    idle_inputs(); bus.ic_data_ok = 1; step();
    idle_inputs();
    check("t4_dropped", 32'(bus.fb_count), 32'd0);
    check("t4_inflight", 32'(bus.inflight), 32'd0);

    // spurious response after reset
    do_reset();
    bus.ic_data_ok = 1; step(); idle_inputs(); step();
    check("t5_perr", 32'(bus.proto_err), 32'd1);
    check("t5_fb",   32'(bus.fb_count),  32'd0);
    check("t5_if",   32'(bus.inflight),  32'd0);

    // reset mid-operation
    do_reset();
    build(3, 4, 32'h1c000300);
    rst = 1; bus.pc_valid = 1; bus.ic_addr_ok = 1; step();
    rst = 0; idle_inputs();
    #1;
    check("t6_if",   32'(bus.inflight),  32'd0);
    check("t6_fb",   32'(bus.fb_count),  32'd0);
    check("t6_ov",   32'(bus.out_valid), 32'd0);
    check("t6_perr", 32'(bus.proto_err), 32'd0);

    // random traffic
    bus.pc = 32'h1c001000;
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 299) == 0);
      bus.flush      = ($urandom_range(0, 19) == 0);
      bus.pc_valid   = ($urandom_range(0, 9) < 8);
      bus.ic_addr_ok = ($urandom_range(0, 9) < 7);
      bus.ic_data_ok = (m_if.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.ic_rdata   = $urandom;
      bus.out_ready  = ($urandom_range(0, 9) < 6);
      step();
      if (m_issued) bus.pc = bus.pc + 4;
    end
    rst = 0; idle_inputs(); step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
